// File: rtl/keystone_pkg.sv
// Shared types and helpers for the keystone warp stage: pixel layout, FSM states, tdata packing.
package keystone_pkg;

    localparam int unsigned FRAC   = 24;
    localparam int unsigned PIX_W  = 24;
    localparam int unsigned PACK_W = 30;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [2:0] {CAPTURE, CALC, DIVIDE, FETCH, OUTPUT} state_t;

    // G=[9:2], B=[19:12], R=[29:22]; unused positions are zero
    function automatic logic [PACK_W-1:0] pack_pixel(input pixel_t p);
        logic [PACK_W-1:0] d;
        d        = '0;
        d[29:22] = p.r;
        d[19:12] = p.b;
        d[9:2]   = p.g;
        return d;
    endfunction

    function automatic pixel_t unpack_pixel(input logic [PACK_W-1:0] d);
        pixel_t p;
        p.r = d[29:22];
        p.b = d[19:12];
        p.g = d[9:2];
        return p;
    endfunction

endpackage

// File: rtl/keystone_divider.sv
// Sequential signed restoring divider, one quotient bit per clock, quotient rounded half away from zero.
module keystone_divider #(
    parameter int unsigned NW = 64
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 aclken,
    input  logic                 start,
    input  logic signed [NW-1:0] num,
    input  logic        [NW-1:0] den,
    output logic                 done,
    output logic signed [NW-1:0] quo
);

    localparam int unsigned CW = $clog2(NW);

    logic          busy;
    logic          neg;
    logic [CW-1:0] cnt;
    logic [NW-1:0] rem;
    logic [NW-1:0] acc;
    logic [NW-1:0] dvs;

    logic [NW:0]   rem_sh;
    logic          ge;
    logic [NW:0]   rem_nx;
    logic [NW-1:0] acc_nx;
    logic          round_up;
    logic [NW-1:0] mag;

    // One restoring step; rounding compares twice the final remainder with the divisor
    always_comb begin
        rem_sh   = {rem, acc[NW-1]};
        ge       = rem_sh >= {1'b0, dvs};
        rem_nx   = ge ? (rem_sh - {1'b0, dvs}) : rem_sh;
        acc_nx   = {acc[NW-2:0], ge};
        round_up = {rem_nx, 1'b0} >= {2'b00, dvs};
        mag      = acc_nx + NW'(round_up);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            busy <= 1'b0;
            neg  <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            acc  <= '0;
            dvs  <= '0;
            quo  <= '0;
        end else if (aclken) begin
            done <= 1'b0;
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                rem  <= '0;
                acc  <= num[NW-1] ? NW'(-num) : NW'(num);
                neg  <= num[NW-1];
                dvs  <= den;
            end else if (busy) begin
                rem <= rem_nx[NW-1:0];
                acc <= acc_nx;
                cnt <= cnt + CW'(1);
                if (cnt == CW'(NW-1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    quo  <= neg ? -mag : mag;
                end
            end
        end
    end

endmodule

// File: rtl/keystone.sv
// AXI4-Stream keystone warp: captures a frame, then emits it resampled through homography H.
module keystone
    import keystone_pkg::*;
#(
    parameter int unsigned FRAME_W = 1920,
    parameter int unsigned FRAME_H = 1080,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned COEF_W  = 32
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              aclken,
    input  logic              SW_RESET,
    input  logic              ENABLE_KEYSTONE,
    input  logic [COEF_W-1:0] H11,
    input  logic [COEF_W-1:0] H12,
    input  logic [COEF_W-1:0] H13,
    input  logic [COEF_W-1:0] H21,
    input  logic [COEF_W-1:0] H22,
    input  logic [COEF_W-1:0] H23,
    input  logic [COEF_W-1:0] H31,
    input  logic [COEF_W-1:0] H32,
    input  logic [COEF_W-1:0] H33,
    input  logic [DATA_W-1:0] s_axis_video_tdata_in,
    input  logic              s_axis_video_tvalid_in,
    output logic              s_axis_video_tready_out,
    input  logic              s_axis_video_tuser_in,
    input  logic              s_axis_video_tlast_in,
    output logic [DATA_W-1:0] s_axis_video_tdata_out,
    output logic              s_axis_video_tvalid_out,
    input  logic              s_axis_video_tready_in,
    output logic              s_axis_video_tuser_out,
    output logic              s_axis_video_tlast_out
);

    localparam int unsigned NPIX = FRAME_W * FRAME_H;
    localparam int unsigned AW   = $clog2(NPIX);
    localparam int unsigned XW   = $clog2(FRAME_W);
    localparam int unsigned YW   = $clog2(FRAME_H);
    localparam int unsigned PW   = 2 * COEF_W;

    state_t                     state;
    logic                       rst;
    logic signed [COEF_W-1:0]   h_in [9];
    logic signed [COEF_W-1:0]   h_r  [9];
    logic [XW-1:0]              ox;
    logic [YW-1:0]              oy;
    logic [AW-1:0]              wr_addr;
    logic                       capturing;
    logic                       rd_hit;
    logic                       out_valid, out_user, out_last;
    logic [DATA_W-1:0]          out_data;

    logic                       bypass_c, capture_beat_c, w_pos_c, div_start_c;
    logic                       out_user_c, out_last_c, sx_ok_c, sy_ok_c;
    logic signed [PW-1:0]       x_e, y_e, xw_c, yw_c, w_c;
    logic signed [PW-1:0]       q_x, q_y;
    logic                       done_x, done_y;
    logic [AW-1:0]              cap_addr_c, rd_addr_c, ram_addr_c;
    pixel_t                     mem [NPIX];
    pixel_t                     ram_q;

    assign rst  = areset | SW_RESET;
    assign h_in = '{H11, H12, H13, H21, H22, H23, H31, H32, H33};

    // Projective transform of the current output coordinate; Q8.24 scale cancels in the divide
    assign x_e  = PW'(ox);
    assign y_e  = PW'(oy);
    assign xw_c = PW'(h_r[0]) * x_e + PW'(h_r[1]) * y_e + PW'(h_r[2]);
    assign yw_c = PW'(h_r[3]) * x_e + PW'(h_r[4]) * y_e + PW'(h_r[5]);
    assign w_c  = PW'(h_r[6]) * x_e + PW'(h_r[7]) * y_e + PW'(h_r[8]);

    assign w_pos_c        = !w_c[PW-1] && (w_c != '0);
    assign div_start_c    = (state == CALC) && w_pos_c;
    assign bypass_c       = !ENABLE_KEYSTONE && (state == CAPTURE);
    assign capture_beat_c = (state == CAPTURE) && ENABLE_KEYSTONE && s_axis_video_tvalid_in
                            && (s_axis_video_tuser_in || capturing);
    assign out_user_c     = (ox == '0) && (oy == '0);
    assign out_last_c     = (ox == XW'(FRAME_W-1));

    assign sx_ok_c    = !q_x[PW-1] && ($unsigned(q_x) < PW'(FRAME_W));
    assign sy_ok_c    = !q_y[PW-1] && ($unsigned(q_y) < PW'(FRAME_H));
    assign cap_addr_c = s_axis_video_tuser_in ? '0 : wr_addr;
    assign rd_addr_c  = AW'(q_y[YW-1:0]) * AW'(FRAME_W) + AW'(q_x[XW-1:0]);
    assign ram_addr_c = (state == CAPTURE) ? cap_addr_c : rd_addr_c;

    keystone_divider #(.NW(PW)) u_div_x (
        .aclk(aclk), .areset(rst), .aclken(aclken), .start(div_start_c),
        .num(xw_c), .den(w_c), .done(done_x), .quo(q_x)
    );

    keystone_divider #(.NW(PW)) u_div_y (
        .aclk(aclk), .areset(rst), .aclken(aclken), .start(div_start_c),
        .num(yw_c), .den(w_c), .done(done_y), .quo(q_y)
    );

    // Single-port frame buffer: written during capture, read once per output pixel
    always_ff @(posedge aclk) begin
        if (aclken) begin
            if (capture_beat_c) begin
                mem[ram_addr_c] <= unpack_pixel(s_axis_video_tdata_in[PACK_W-1:0]);
            end
            ram_q <= mem[ram_addr_c];
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state     <= CAPTURE;
            h_r       <= '{default: '0};
            ox        <= '0;
            oy        <= '0;
            wr_addr   <= '0;
            capturing <= 1'b0;
            rd_hit    <= 1'b0;
            out_valid <= 1'b0;
            out_user  <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (aclken) begin
            case (state)
                CAPTURE: begin
                    if (!ENABLE_KEYSTONE) begin
                        capturing <= 1'b0;
                        wr_addr   <= '0;
                    end else if (capture_beat_c) begin
                        capturing <= 1'b1;
                        wr_addr   <= cap_addr_c + AW'(1);
                        if (cap_addr_c == AW'(NPIX-1)) begin
                            state     <= CALC;
                            capturing <= 1'b0;
                            wr_addr   <= '0;
                            h_r       <= h_in;
                            ox        <= '0;
                            oy        <= '0;
                        end
                    end
                end
                CALC: begin
                    if (w_pos_c) begin
                        state <= DIVIDE;
                    end else begin
                        out_data  <= '0;
                        out_valid <= 1'b1;
                        out_user  <= out_user_c;
                        out_last  <= out_last_c;
                        state     <= OUTPUT;
                    end
                end
                DIVIDE: begin
                    if (done_x && done_y) begin
                        rd_hit <= sx_ok_c && sy_ok_c;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    out_data  <= rd_hit ? DATA_W'(pack_pixel(ram_q)) : '0;
                    out_valid <= 1'b1;
                    out_user  <= out_user_c;
                    out_last  <= out_last_c;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (s_axis_video_tready_in) begin
                        out_valid <= 1'b0;
                        out_user  <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= CALC;
                        if (out_last_c) begin
                            ox <= '0;
                            if (oy == YW'(FRAME_H-1)) begin
                                oy    <= '0;
                                state <= CAPTURE;
                            end else begin
                                oy <= oy + YW'(1);
                            end
                        end else begin
                            ox <= ox + XW'(1);
                        end
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

    assign s_axis_video_tdata_out  = bypass_c ? s_axis_video_tdata_in  : out_data;
    assign s_axis_video_tvalid_out = bypass_c ? s_axis_video_tvalid_in : out_valid;
    assign s_axis_video_tuser_out  = bypass_c ? s_axis_video_tuser_in  : out_user;
    assign s_axis_video_tlast_out  = bypass_c ? s_axis_video_tlast_in  : out_last;
    assign s_axis_video_tready_out = bypass_c ? s_axis_video_tready_in : (state == CAPTURE);

endmodule

// File: tb/tb_keystone.sv
// Scoreboard bench for keystone on an 8x4 frame: warp modes, backpressure, resets, bypass.
module tb_keystone;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 32;
    localparam logic [63:0] KEEP = 64'h0000_0000_3FCF_F3FC;
    localparam logic [31:0] ONE  = 32'h0100_0000;

    typedef struct {
        logic [63:0] d;
        logic        u;
        logic        l;
    } exp_t;

    logic          aclk = 1'b0;
    logic          areset, aclken, sw_reset, enable;
    logic [CW-1:0] h [9];
    logic [DW-1:0] tdata_in, tdata_out;
    logic          tvalid_in, tready_out, tuser_in, tlast_in;
    logic          tvalid_out, tready_in, tuser_out, tlast_out;

    logic byp_mode = 1'b0, byp_ready = 1'b0;
    logic bp_en = 1'b0, bp_tog = 1'b1, hold_ready = 1'b1;
    logic mon_en = 1'b0;
    int   bp_cnt = 0;
    int   errors = 0, checks = 0;
    exp_t exp_q[$];

    assign tready_in = byp_mode ? byp_ready : (bp_en ? bp_tog : hold_ready);

    initial forever #5 aclk = ~aclk;

    keystone #(.FRAME_W(W), .FRAME_H(H), .DATA_W(DW), .COEF_W(CW)) dut (
        .aclk(aclk), .areset(areset), .aclken(aclken), .SW_RESET(sw_reset),
        .ENABLE_KEYSTONE(enable),
        .H11(h[0]), .H12(h[1]), .H13(h[2]), .H21(h[3]), .H22(h[4]), .H23(h[5]),
        .H31(h[6]), .H32(h[7]), .H33(h[8]),
        .s_axis_video_tdata_in(tdata_in), .s_axis_video_tvalid_in(tvalid_in),
        .s_axis_video_tready_out(tready_out), .s_axis_video_tuser_in(tuser_in),
        .s_axis_video_tlast_in(tlast_in), .s_axis_video_tdata_out(tdata_out),
        .s_axis_video_tvalid_out(tvalid_out), .s_axis_video_tready_in(tready_in),
        .s_axis_video_tuser_out(tuser_out), .s_axis_video_tlast_out(tlast_out)
    );

    function automatic logic [63:0] pix(input int seed, input int x, input int y);
        logic [63:0] d;
        d        = '0;
        d[29:22] = 8'(seed + 16 * y + x);
        d[9:2]   = 8'(seed * 3 + 7 * x + y);
        d[19:12] = 8'(255 - x - 8 * y);
        return d;
    endfunction

    // Downstream ready toggling every 3 cycles while backpressure is on
    initial forever begin
        @(posedge aclk); #1;
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt == 3) begin
                bp_cnt = 0;
                bp_tog = ~bp_tog;
            end
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks stability while stalled
    initial begin
        logic        stall_prev;
        logic [63:0] held_d;
        logic        held_u, held_l;
        exp_t        e;
        stall_prev = 1'b0;
        held_d = '0; held_u = 1'b0; held_l = 1'b0;
        forever begin
            @(negedge aclk);
            if (!mon_en) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (!tvalid_out || tdata_out != held_d || tuser_out != held_u || tlast_out != held_l) begin
                        errors++;
                        $display("FAIL stall_hold got v=%b d=%h u=%b l=%b want v=1 d=%h u=%b l=%b",
                                 tvalid_out, tdata_out, tuser_out, tlast_out, held_d, held_u, held_l);
                    end
                end
                if (tvalid_out && tready_in) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_beat got d=%h u=%b l=%b want no beat",
                                 tdata_out, tuser_out, tlast_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (tdata_out != e.d || tuser_out != e.u || tlast_out != e.l) begin
                            errors++;
                            $display("FAIL pixel got d=%h u=%b l=%b want d=%h u=%b l=%b",
                                     tdata_out, tuser_out, tlast_out, e.d, e.u, e.l);
                        end
                    end
                end
                stall_prev = tvalid_out && !tready_in;
                held_d = tdata_out; held_u = tuser_out; held_l = tlast_out;
            end
        end
    end

    // mode 0 identity, 1 translate by +2 columns, 2 degenerate (w = 0)
    task automatic set_h(input int mode);
        for (int i = 0; i < 9; i++) h[i] = '0;
        if (mode != 2) begin
            h[0] = ONE; h[4] = ONE; h[8] = ONE;
        end
        if (mode == 1) h[2] = 32'h0200_0000;
    endtask

    task automatic push_frame(input int seed, input int mode);
        exp_t e;
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                if (mode == 2 || (mode == 1 && x + 2 >= int'(W))) e.d = '0;
                else e.d = pix(seed, (mode == 1) ? x + 2 : x, y);
                e.u = (x == 0 && y == 0);
                e.l = (x == int'(W) - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic u, input logic l);
        int n;
        tdata_in  = d | ({$urandom(), $urandom()} & ~KEEP);
        tuser_in  = u;
        tlast_in  = l;
        tvalid_in = 1'b1;
        n = 0;
        @(negedge aclk);
        while (!tready_out && n < 5000) begin
            @(negedge aclk);
            n++;
        end
        if (!tready_out) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got tready_out=0 want 1");
        end
        @(posedge aclk); #1;
    endtask

    task automatic send_frame(input int seed, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(pix(seed, i % int'(W), i / int'(W)), i == 0, (i % int'(W)) == int'(W) - 1);
        end
        tvalid_in = 1'b0;
        tuser_in  = 1'b0;
        tlast_in  = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 8000) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got %0d pending want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic pulse_sw_reset();
        @(posedge aclk); #1;
        sw_reset = 1'b1;
        @(posedge aclk); #1;
        sw_reset = 1'b0;
    endtask

    initial begin
        int n;
        areset = 1'b1; sw_reset = 1'b0; aclken = 1'b1; enable = 1'b1;
        tdata_in = '0; tvalid_in = 1'b0; tuser_in = 1'b0; tlast_in = 1'b0;
        set_h(0);
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({tvalid_out, tuser_out, tlast_out} != 3'b000 || tdata_out != '0 || !tready_out) begin
            errors++;
            $display("FAIL reset_state got v=%b u=%b l=%b d=%h rdy=%b want 0 0 0 0 1",
                     tvalid_out, tuser_out, tlast_out, tdata_out, tready_out);
        end
        mon_en = 1'b1;

        set_h(0); push_frame(1, 0); send_frame(1, W * H); drain("identity");
        set_h(1); push_frame(2, 1); send_frame(2, W * H); drain("translate");
        set_h(2); push_frame(3, 2); send_frame(3, W * H); drain("degenerate");

        bp_en = 1'b1;
        set_h(0); push_frame(4, 0); send_frame(4, W * H); drain("backpressure");
        bp_en = 1'b0;

        // Reset while the first warped pixel is stalled: nothing of that frame may escape
        hold_ready = 1'b0;
        send_frame(5, W * H);
        n = 0;
        while (!tvalid_out && n < 500) begin
            @(negedge aclk);
            n++;
        end
        checks++;
        if (!tvalid_out) begin
            errors++;
            $display("FAIL first_pixel_timeout got tvalid_out=0 want 1");
        end
        mon_en = 1'b0;
        pulse_sw_reset();
        @(negedge aclk);
        checks++;
        if (tvalid_out || !tready_out) begin
            errors++;
            $display("FAIL out_reset got v=%b rdy=%b want v=0 rdy=1", tvalid_out, tready_out);
        end
        hold_ready = 1'b1;
        mon_en = 1'b1;

        // Reset mid-capture, then a fresh frame
        send_frame(6, 13);
        pulse_sw_reset();
        push_frame(7, 0); send_frame(7, W * H); drain("after_reset");

        // Bypass: outputs follow inputs in the same cycle
        mon_en = 1'b0;
        byp_mode = 1'b1;
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge aclk); #1;
            tdata_in  = {$urandom(), $urandom()};
            tvalid_in = 1'(i & 1);
            tuser_in  = (i == 2);
            tlast_in  = (i == 3 || i == 4);
            byp_ready = 1'(i >> 1);
            #1;
            checks++;
            if ({tdata_out, tvalid_out, tuser_out, tlast_out, tready_out} !=
                {tdata_in, tvalid_in, tuser_in, tlast_in, byp_ready}) begin
                errors++;
                $display("FAIL bypass[%0d] got d=%h v=%b u=%b l=%b rdy=%b want d=%h v=%b u=%b l=%b rdy=%b",
                         i, tdata_out, tvalid_out, tuser_out, tlast_out, tready_out,
                         tdata_in, tvalid_in, tuser_in, tlast_in, byp_ready);
            end
        end
        tvalid_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
